// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU run/step/stop sequencer.
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        CmdRun   = 2'd0,
        CmdStep  = 2'd1,
        CmdStop  = 2'd2,
        CmdReset = 2'd3
    } cmd_e;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StRun       = 3'd1,
        StStep      = 3'd2,
        StStopped   = 3'd3,
        StResetCore = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ReasonNone     = 3'd0,
        ReasonUser     = 3'd1,
        ReasonStep     = 3'd2,
        ReasonSelfLoop = 3'd3,
        ReasonTimeout  = 3'd4,
        ReasonBreak    = 3'd5
    } reason_e;

    // Cycles the core reset is held after entering StResetCore.
    localparam int unsigned RST_HOLD = 2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step/stop sequencer for the accumulator CPU core; detects jump-to-self termination.
// Optional breakpoint support is built when CPU_RUN_CTRL_BREAKPOINT_EN is defined.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned IP_W       = 8,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MAX_CYCLES = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    output logic             cmd_ready,
    input  logic [IP_W-1:0]  ip,
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    input  logic             bp_en,
    input  logic [IP_W-1:0]  bp_addr,
`endif
    output logic             core_en,
    output logic             core_rst,
    output logic [2:0]       state,
    output logic [2:0]       stop_reason,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam bit          WD_EN     = (MAX_CYCLES != 0);
    localparam int unsigned RST_CNT_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    state_e                 state_q, state_d;
    reason_e                reason_q, reason_d;
    logic [IP_W-1:0]        prev_ip_q, prev_ip_d;
    logic                   prev_valid_q, prev_valid_d;
    logic                   done_q, done_d;
    logic [RST_CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic                   bp_skip_q, bp_skip_d;

    cmd_e                   cmd;
    logic                   cmd_fire;
    logic                   acc_run, acc_step, acc_stop, acc_reset;
    logic                   in_run, self_loop, bp_hit, wd_last, wd_over;
    logic                   run_mask, stop_run;
    logic                   bp_en_w;
    logic [IP_W-1:0]        bp_addr_w;
    logic [31:0]            cnt_ext;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    assign bp_en_w   = bp_en;
    assign bp_addr_w = bp_addr;
`else
    assign bp_en_w   = 1'b0;
    assign bp_addr_w = '0;
`endif

    assign cmd       = cmd_e'(cmd_op);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign acc_run   = cmd_fire && (cmd == CmdRun);
    assign acc_step  = cmd_fire && (cmd == CmdStep);
    assign acc_stop  = cmd_fire && (cmd == CmdStop);
    assign acc_reset = cmd_fire && (cmd == CmdReset);

    assign in_run    = (state_q == StRun);
    assign self_loop = prev_valid_q && (ip == prev_ip_q);
    assign bp_hit    = bp_en_w && (ip == bp_addr_w) && !bp_skip_q;
    assign cnt_ext   = 32'(cycle_cnt);

    // The last allowed cycle still executes; only an already-exhausted budget masks the enable.
    assign wd_last   = WD_EN && (cnt_ext == MAX_CYCLES - 32'd1);
    assign wd_over   = WD_EN && (cnt_ext >= MAX_CYCLES);

    assign run_mask  = self_loop || bp_hit || wd_over || acc_stop || acc_reset;
    assign stop_run  = in_run && (run_mask || wd_last);
    assign core_en   = (in_run && !run_mask) || (state_q == StStep);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StResetCore;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        reason_d     = reason_q;
        prev_ip_d    = prev_ip_q;
        prev_valid_d = prev_valid_q;
        rst_cnt_d    = rst_cnt_q;
        bp_skip_d    = 1'b0;

        if (core_en) begin
            prev_ip_d    = ip;
            prev_valid_d = 1'b1;
        end

        unique case (state_q)
            StIdle, StStopped: begin
                if (acc_run) begin
                    state_d      = StRun;
                    reason_d     = ReasonNone;
                    prev_valid_d = 1'b0;
                    // Resuming on a breakpoint address must be able to execute past it.
                    bp_skip_d    = (state_q == StStopped);
                end else if (acc_step) begin
                    state_d  = StStep;
                    reason_d = ReasonNone;
                end else if (acc_reset) begin
                    state_d   = StResetCore;
                    rst_cnt_d = '0;
                end
            end
            StRun: begin
                if (acc_reset) begin
                    state_d   = StResetCore;
                    rst_cnt_d = '0;
                end else if (stop_run) begin
                    state_d = StStopped;
                    if (self_loop) begin
                        reason_d = ReasonSelfLoop;
                    end else if (bp_hit) begin
                        reason_d = ReasonBreak;
                    end else if (wd_last || wd_over) begin
                        reason_d = ReasonTimeout;
                    end else begin
                        reason_d = ReasonUser;
                    end
                end
            end
            StStep: begin
                state_d  = StStopped;
                reason_d = ReasonStep;
            end
            StResetCore: begin
                reason_d     = ReasonNone;
                prev_valid_d = 1'b0;
                if (rst_cnt_q == RST_CNT_W'(RST_HOLD - 1)) begin
                    state_d = StIdle;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
                end
            end
            default: begin
                state_d   = StResetCore;
                rst_cnt_d = '0;
            end
        endcase

        done_d = (state_d == StStopped) && (state_q != StStopped);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            reason_q     <= ReasonNone;
            prev_ip_q    <= '0;
            prev_valid_q <= 1'b0;
            done_q       <= 1'b0;
            rst_cnt_q    <= '0;
            bp_skip_q    <= 1'b0;
        end else begin
            reason_q     <= reason_d;
            prev_ip_q    <= prev_ip_d;
            prev_valid_q <= prev_valid_d;
            done_q       <= done_d;
            rst_cnt_q    <= rst_cnt_d;
            bp_skip_q    <= bp_skip_d;
        end
    end

    always_comb begin
        cmd_ready = 1'b0;
        core_rst  = 1'b0;
        unique case (state_q)
            StIdle, StRun, StStopped: cmd_ready = 1'b1;
            StStep:                   cmd_ready = 1'b0;
            StResetCore:              core_rst  = 1'b1;
            default:                  core_rst  = 1'b1;
        endcase
    end

    assign state       = state_q;
    assign stop_reason = reason_q;
    assign done        = done_q;

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (state_q == StResetCore),
        .inc   (core_en),
        .count (cycle_cnt)
    );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a small registered-IP core model.
module tb_cpu_run_ctrl;

    localparam int unsigned IP_W  = 8;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned MAXC  = 20;

    localparam logic [1:0] OP_RUN = 2'd0, OP_STEP = 2'd1, OP_STOP = 2'd2, OP_RESET = 2'd3;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic [1:0]       cmd_op;
    logic             cmd_ready;
    logic [IP_W-1:0]  ip;
    logic             core_en;
    logic             core_rst;
    logic [2:0]       state;
    logic [2:0]       stop_reason;
    logic             done;
    logic [CNT_W-1:0] cycle_cnt;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
    logic             bp_en;
    logic [IP_W-1:0]  bp_addr;
`endif

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int done_cnt = 0;
    int prog = 0;

    always #5 clk = ~clk;

    cpu_run_ctrl #(
        .IP_W       (IP_W),
        .CNT_W      (CNT_W),
        .MAX_CYCLES (MAXC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_ready   (cmd_ready),
        .ip          (ip),
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
`endif
        .core_en     (core_en),
        .core_rst    (core_rst),
        .state       (state),
        .stop_reason (stop_reason),
        .done        (done),
        .cycle_cnt   (cycle_cnt)
    );

    // prog 0: 0..6, jump to 8, jump to 7, halt loop at 7. prog 1: endless 0<->1 loop.
    function automatic logic [IP_W-1:0] next_ip(input logic [IP_W-1:0] cur, input int p);
        if (p == 1) return (cur == 8'd0) ? 8'd1 : 8'd0;
        case (cur)
            8'd6:    return 8'd8;
            8'd8:    return 8'd7;
            8'd7:    return 8'd7;
            default: return cur + 8'd1;
        endcase
    endfunction

    always @(posedge clk) begin
        if (core_rst) ip <= '0;
        else if (core_en) ip <= next_ip(ip, prog);
    end

    always @(posedge clk) begin
        if (core_en) en_cnt++;
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op);
        cmd_valid = 1'b1;
        cmd_op    = op;
        for (int i = 0; i < 20 && !cmd_ready; i++) tick();
        check("cmd_accepted", 32'(cmd_ready), 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        check("done_seen", 32'(done), 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 10 && state != 3'd0; i++) tick();
        check("reached_idle", 32'(state), 0);
    endtask

    initial begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = OP_RUN;
        ip        = '0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        bp_en     = 1'b0;
        bp_addr   = '0;
`endif
        tick();
        tick();
        check("rst_state", 32'(state), 4);
        check("rst_core_rst", 32'(core_rst), 1);
        check("rst_core_en", 32'(core_en), 0);
        check("rst_cycle_cnt", 32'(cycle_cnt), 0);
        check("rst_reason", 32'(stop_reason), 0);
        check("rst_done", 32'(done), 0);
        rst = 1'b1;
        tick();
        check("hold_core_rst", 32'(core_rst), 1);
        check("hold_cmd_ready", 32'(cmd_ready), 0);
        tick();
        check("idle_state", 32'(state), 0);
        check("idle_core_rst", 32'(core_rst), 0);
        check("idle_cmd_ready", 32'(cmd_ready), 1);
        check("idle_cycle_cnt", 32'(cycle_cnt), 0);

        // Run to the halt loop at 7.
        en_cnt   = 0;
        done_cnt = 0;
        send(OP_RUN);
        check("run_state", 32'(state), 1);
        wait_done(50);
        check("halt_state", 32'(state), 3);
        check("halt_reason", 32'(stop_reason), 3);
        check("halt_cycle_cnt", 32'(cycle_cnt), 9);
        check("halt_ip", 32'(ip), 7);
        check("halt_en_cnt", 32'(en_cnt), 9);
        tick();
        check("done_one_cycle", 32'(done), 0);
        check("done_count", 32'(done_cnt), 1);
        check("stopped_core_en", 32'(core_en), 0);

        // STOP in STOPPED is ignored.
        cmd_valid = 1'b1;
        cmd_op    = OP_STOP;
        tick();
        cmd_valid = 1'b0;
        check("stop_ignored_state", 32'(state), 3);
        check("stop_ignored_done", 32'(done), 0);

        // Resume: one enabled cycle at 7, then STOP collides with the self-loop.
        send(OP_RUN);
        check("resume_reason_clr", 32'(stop_reason), 0);
        check("resume_core_en", 32'(core_en), 1);
        tick();
        cmd_valid = 1'b1;
        cmd_op    = OP_STOP;
        check("loop_masked_en", 32'(core_en), 0);
        tick();
        cmd_valid = 1'b0;
        check("prio_state", 32'(state), 3);
        check("prio_reason", 32'(stop_reason), 3);
        check("prio_done", 32'(done), 1);
        check("prio_cycle_cnt", 32'(cycle_cnt), 10);

        // Single steps 0->1->2->3.
        send(OP_RESET);
        wait_idle();
        check("reset_cycle_cnt", 32'(cycle_cnt), 0);
        check("reset_ip", 32'(ip), 0);
        en_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            send(OP_STEP);
            check("step_state", 32'(state), 2);
            check("step_cmd_ready", 32'(cmd_ready), 0);
            check("step_core_en", 32'(core_en), 1);
            tick();
            check("step_stopped", 32'(state), 3);
            check("step_reason", 32'(stop_reason), 2);
            check("step_ip", 32'(ip), 32'(k + 1));
            check("step_core_en_off", 32'(core_en), 0);
        end
        check("step_en_cnt", 32'(en_cnt), 3);
        check("step_cycle_cnt", 32'(cycle_cnt), 3);

        // Watchdog on an endless loop.
        send(OP_RESET);
        wait_idle();
        prog   = 1;
        en_cnt = 0;
        send(OP_RUN);
        wait_done(100);
        check("wd_reason", 32'(stop_reason), 4);
        check("wd_cycle_cnt", 32'(cycle_cnt), 20);
        check("wd_en_cnt", 32'(en_cnt), 20);
        tick();
        send(OP_RUN);
        check("wd_over_core_en", 32'(core_en), 0);
        tick();
        check("wd_over_reason", 32'(stop_reason), 4);
        check("wd_over_done", 32'(done), 1);
        check("wd_over_cycle_cnt", 32'(cycle_cnt), 20);
        check("wd_over_en_cnt", 32'(en_cnt), 20);

        // RESET mid-RUN: no done pulse.
        send(OP_RESET);
        wait_idle();
        send(OP_RUN);
        for (int i = 0; i < 5; i++) tick();
        done_cnt = 0;
        send(OP_RESET);
        check("mid_reset_state", 32'(state), 4);
        check("mid_reset_core_rst", 32'(core_rst), 1);
        check("mid_reset_core_en", 32'(core_en), 0);
        check("mid_reset_cmd_ready", 32'(cmd_ready), 0);
        tick();
        check("mid_reset_hold", 32'(core_rst), 1);
        tick();
        check("mid_reset_idle", 32'(state), 0);
        check("mid_reset_core_rst_off", 32'(core_rst), 0);
        check("mid_reset_cycle_cnt", 32'(cycle_cnt), 0);
        check("mid_reset_reason", 32'(stop_reason), 0);
        check("mid_reset_no_done", 32'(done_cnt), 0);

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
        prog    = 0;
        bp_en   = 1'b1;
        bp_addr = 8'd4;
        send(OP_RUN);
        wait_done(50);
        check("bp_reason", 32'(stop_reason), 5);
        check("bp_ip", 32'(ip), 4);
        check("bp_cycle_cnt", 32'(cycle_cnt), 4);
        tick();
        send(OP_RUN);
        wait_done(50);
        check("bp_pass_reason", 32'(stop_reason), 3);
        check("bp_pass_ip", 32'(ip), 7);
        check("bp_pass_cycle_cnt", 32'(cycle_cnt), 9);
        bp_en = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step/stop sequencer for the 8-bit accumulator CPU core. Gates the core through a clock-enable and drives the core reset. Detects program termination as a jump-to-self, i.e. IP unchanged across an enabled cycle. Counts executed cycles and reports why the core stopped, so benches and the host command interface no longer poll IP themselves.

Parameters:
IP_W, 8, instruction pointer width
CNT_W, 16, executed-cycle counter width
MAX_CYCLES, 1000, watchdog limit on executed cycles; 0 disables the watchdog

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
cmd_valid  in  1  command request
cmd_op  in  2  command: RUN=0, STEP=1, STOP=2, RESET=3
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
ip  in  IP_W  core instruction pointer (registered in core)
core_en  out  1  core clock-enable
core_rst  out  1  core reset, active-high
state  out  3  current FSM state
stop_reason  out  3  NONE=0, USER=1, STEP=2, SELF_LOOP=3, TIMEOUT=4, BREAK=5
done  out  1  one-cycle pulse on entry to STOPPED
cycle_cnt  out  CNT_W  cycles with core_en=1 since last RESET

Behaviour:
- Reset (rst=0 at posedge):
  - state=RESET_CORE, core_rst=1, core_en=0, cycle_cnt=0, stop_reason=NONE, done=0, prev_valid=0.
  - A reset mid-RUN aborts immediately; no done pulse.
- States:
  - IDLE: cmd_ready=1. RUN -> RUN. STEP -> STEP. STOP is ignored. RESET -> RESET_CORE.
  - RUN: cmd_ready=1. core_en is combinational: core_en = (state==RUN) && !stop_cond.
    - stop_cond = (prev_valid && ip==prev_ip) || watchdog_hit || accepted STOP || accepted RESET.
    - On each enabled cycle: prev_ip <= ip, prev_valid <= 1.
    - On stop_cond -> STOPPED, with stop_reason set as follows:
      - self-loop -> SELF_LOOP; watchdog -> TIMEOUT; STOP -> USER.
      - Priority when several are true at once: SELF_LOOP > TIMEOUT > USER.
      - Accepted RESET overrides all of them and goes to RESET_CORE without a done pulse.
  - STEP: cmd_ready=0. core_en=1 for exactly this one cycle, then -> STOPPED with reason STEP.
  - STOPPED: cmd_ready=1. done=1 on the first cycle only.
    - RUN resumes and clears prev_valid, so IP not advancing on a resumed self-loop re-stops after one enabled cycle.
    - STEP -> STEP. STOP is ignored. RESET -> RESET_CORE.
  - RESET_CORE: cmd_ready=0, core_rst=1 for 2 cycles, cycle_cnt cleared, stop_reason=NONE, then -> IDLE.
- Entering RUN or STEP sets stop_reason=NONE.
- cycle_cnt increments on every cycle with core_en=1 and saturates at all-ones.
- watchdog_hit = (MAX_CYCLES!=0) && (cycle_cnt == MAX_CYCLES-1) && core_en_raw, where core_en_raw is the enable before stop_cond masking. The core therefore executes exactly MAX_CYCLES enabled cycles.
  - If a resume is issued with cycle_cnt >= MAX_CYCLES, the core stops on the first RUN cycle with reason TIMEOUT and 0 enabled cycles.
- cmd_op values are sampled only on handshake. cmd_valid without cmd_ready has no effect; the requester holds it.

Optional Feature:
CPU_RUN_CTRL_BREAKPOINT_EN:
- Defined: adds inputs bp_en (1 bit) and bp_addr (IP_W bits).
  - In RUN, when bp_en && ip==bp_addr, this is a stop_cond with reason BREAK, priority just below SELF_LOOP.
  - The instruction at bp_addr is not executed.
  - A RUN issued from STOPPED while ip==bp_addr ignores the breakpoint for the first cycle so execution can continue past it.
- Undefined: the ports are absent and reason BREAK is never produced.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - cmd_e (2-bit command enum)
  - state_e (IDLE, RUN, STEP, STOPPED, RESET_CORE)
  - reason_e (3-bit)
  - the reset hold length constant RST_HOLD=2
- One sub-module: sat_counter (parameterised width, inc/clear, saturating), used for cycle_cnt.

Test Plan:
- Reset held low 2 cycles, then released -> core_rst=1 for 2 cycles, state IDLE, cycle_cnt=0, cmd_ready=1.
- Program with halt loop at IP=7, RUN issued -> core_en high until IP repeats 7, done pulse, stop_reason=SELF_LOOP, cycle_cnt=9.
- MAX_CYCLES=20, infinite two-instruction loop, RUN -> core_en drops after exactly 20 enabled cycles, stop_reason=TIMEOUT, cycle_cnt=20.
- From STOPPED, STEP three times -> core_en high exactly 1 cycle each, IP advances 0->1->2->3, stop_reason=STEP, cmd_ready low during each STEP.
- STOP issued on the same cycle IP repeats -> stop_reason=SELF_LOOP (priority). RESET issued mid-RUN -> no done pulse, core_rst 2 cycles, IDLE, cycle_cnt=0.
- With CPU_RUN_CTRL_BREAKPOINT_EN, bp_addr=4 -> stops with IP=4, reason BREAK. RUN again -> passes IP 4 and stops at self-loop.
